// File: rtl/haar_pkg.sv
// Shared window geometry, FSM state type and raster-index helper for the Haar integral builder.
package haar_pkg;

    localparam int unsigned WIN_W    = 20;
    localparam int unsigned WIN_H    = 20;
    localparam int unsigned WIN_SIZE = WIN_W * WIN_H;
    localparam int unsigned CRD_W    = 5;
    localparam int unsigned IDX_W    = 9;

    typedef enum logic [1:0] {
        ST_FILL    = 2'd0,
        ST_COMPARE = 2'd1,
        ST_REPORT  = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] win_idx(input logic [CRD_W-1:0] x,
                                                 input logic [CRD_W-1:0] y);
        return IDX_W'(y) * IDX_W'(WIN_W) + IDX_W'(x);
    endfunction

endpackage

// File: rtl/haar_integral_pe.sv
// Integral-image processing element: next row sum and entry value (plus squared variants
// when SQ_INTEGRAL_EN is defined).
module haar_integral_pe #(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic [PIX_W-1:0] i_pix,
    input  logic [ACC_W-1:0] i_rowsum,
    input  logic [ACC_W-1:0] i_above,
    input  logic             i_has_above,
    output logic [ACC_W-1:0] o_rowsum_nxt,
    output logic [ACC_W-1:0] o_entry
`ifdef SQ_INTEGRAL_EN
    ,
    input  logic [ACC_W-1:0] i_sq_rowsum,
    input  logic [ACC_W-1:0] i_sq_above,
    output logic [ACC_W-1:0] o_sq_rowsum_nxt,
    output logic [ACC_W-1:0] o_sq_entry
`endif
);

    assign o_rowsum_nxt = i_rowsum + ACC_W'(i_pix);
    assign o_entry      = o_rowsum_nxt + (i_has_above ? i_above : '0);

`ifdef SQ_INTEGRAL_EN
    logic [2*PIX_W-1:0] w_sq;

    assign w_sq            = i_pix * i_pix;
    assign o_sq_rowsum_nxt = i_sq_rowsum + ACC_W'(w_sq);
    assign o_sq_entry      = o_sq_rowsum_nxt + (i_has_above ? i_sq_above : '0);
`endif

endmodule

// File: rtl/haar_integral_builder.sv
// 20x20 integral-image window builder feeding a combinational Haar comparator.
// Optional squared integral (variance normalisation) enabled by defining SQ_INTEGRAL_EN.
module haar_integral_builder
    import haar_pkg::*;
#(
    parameter int unsigned PIX_W = 8,
    parameter int unsigned ACC_W = 32
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             PIX_VALID,
    input  logic [PIX_W-1:0] PIX_DATA,
    output logic             PIX_READY,
    input  logic             CLEAR,
    output logic [ACC_W-1:0] integral_buffer [WIN_SIZE],
    output logic             START,
    input  logic             is_face,
    output logic             FACE_OUT,
    output logic             FACE_VALID
`ifdef SQ_INTEGRAL_EN
    ,
    output logic [ACC_W-1:0] sq_integral_buffer [WIN_SIZE]
`endif
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CRD_W-1:0]   r_x;
    logic [CRD_W-1:0]   r_y;
    logic [ACC_W-1:0]   r_rowsum;
    logic [ACC_W-1:0]   r_buf [WIN_SIZE];
    logic               r_face;

    logic               w_accept;
    logic               w_last_col;
    logic               w_last_row;
    logic [IDX_W-1:0]   w_idx;
    logic [IDX_W-1:0]   w_above_idx;
    logic [ACC_W-1:0]   w_rowsum_nxt;
    logic [ACC_W-1:0]   w_entry;

`ifdef SQ_INTEGRAL_EN
    logic [ACC_W-1:0]   r_sq_rowsum;
    logic [ACC_W-1:0]   r_sq_buf [WIN_SIZE];
    logic [ACC_W-1:0]   w_sq_rowsum_nxt;
    logic [ACC_W-1:0]   w_sq_entry;
`endif

    assign w_accept    = PIX_VALID & PIX_READY & ~CLEAR;
    assign w_last_col  = (r_x == CRD_W'(WIN_W - 1));
    assign w_last_row  = (r_y == CRD_W'(WIN_H - 1));
    assign w_idx       = win_idx(r_x, r_y);
    // Row 0 has no entry above; the mux keeps the read index in range.
    assign w_above_idx = (r_y == '0) ? w_idx : w_idx - IDX_W'(WIN_W);

    haar_integral_pe #(
        .PIX_W (PIX_W),
        .ACC_W (ACC_W)
    ) u_pe (
        .i_pix           (PIX_DATA),
        .i_rowsum        (r_rowsum),
        .i_above         (r_buf[w_above_idx]),
        .i_has_above     (r_y != '0),
        .o_rowsum_nxt    (w_rowsum_nxt),
        .o_entry         (w_entry)
`ifdef SQ_INTEGRAL_EN
        ,
        .i_sq_rowsum     (r_sq_rowsum),
        .i_sq_above      (r_sq_buf[w_above_idx]),
        .o_sq_rowsum_nxt (w_sq_rowsum_nxt),
        .o_sq_entry      (w_sq_entry)
`endif
    );

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        PIX_READY   = 1'b0;
        START       = 1'b0;
        FACE_VALID  = 1'b0;
        case (r_state)
            ST_FILL: begin
                PIX_READY = 1'b1;
                if (w_accept && w_last_col && w_last_row) begin
                    w_state_nxt = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                START       = ~CLEAR;
                w_state_nxt = ST_REPORT;
            end
            ST_REPORT: begin
                // Already open for the first pixel of the next window.
                PIX_READY   = 1'b1;
                FACE_VALID  = ~CLEAR;
                w_state_nxt = ST_FILL;
            end
            default: w_state_nxt = ST_FILL;
        endcase
        if (CLEAR) begin
            w_state_nxt = ST_FILL;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_x      <= '0;
            r_y      <= '0;
            r_rowsum <= '0;
            for (int unsigned i = 0; i < WIN_SIZE; i++) begin
                r_buf[i] <= '0;
            end
`ifdef SQ_INTEGRAL_EN
            r_sq_rowsum <= '0;
            for (int unsigned i = 0; i < WIN_SIZE; i++) begin
                r_sq_buf[i] <= '0;
            end
`endif
        end else if (CLEAR) begin
            r_x      <= '0;
            r_y      <= '0;
            r_rowsum <= '0;
`ifdef SQ_INTEGRAL_EN
            r_sq_rowsum <= '0;
`endif
        end else if (w_accept) begin
            r_buf[w_idx] <= w_entry;
`ifdef SQ_INTEGRAL_EN
            r_sq_buf[w_idx] <= w_sq_entry;
`endif
            if (w_last_col) begin
                r_x      <= '0;
                r_rowsum <= '0;
                r_y      <= w_last_row ? '0 : r_y + CRD_W'(1);
`ifdef SQ_INTEGRAL_EN
                r_sq_rowsum <= '0;
`endif
            end else begin
                r_x      <= r_x + CRD_W'(1);
                r_rowsum <= w_rowsum_nxt;
`ifdef SQ_INTEGRAL_EN
                r_sq_rowsum <= w_sq_rowsum_nxt;
`endif
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_face <= 1'b0;
        end else if (r_state == ST_COMPARE && !CLEAR) begin
            r_face <= is_face;
        end
    end

    assign integral_buffer = r_buf;
    assign FACE_OUT        = r_face;
`ifdef SQ_INTEGRAL_EN
    assign sq_integral_buffer = r_sq_buf;
`endif

endmodule

// File: tb/tb_haar_integral_builder.sv
// Directed scoreboard bench for haar_integral_builder; expectations come from a rectangle-sum model.
module tb_haar_integral_builder;
    import haar_pkg::*;

    localparam int PW = 8;
    localparam int AW = 32;

    logic          CLK = 1'b0;
    logic          RESET_N;
    logic          PIX_VALID;
    logic [PW-1:0] PIX_DATA;
    logic          PIX_READY;
    logic          CLEAR;
    logic [AW-1:0] ib [WIN_SIZE];
    logic          START;
    logic          is_face;
    logic          FACE_OUT;
    logic          FACE_VALID;
`ifdef SQ_INTEGRAL_EN
    logic [AW-1:0] sqb [WIN_SIZE];
`endif

    haar_integral_builder #(
        .PIX_W (PW),
        .ACC_W (AW)
    ) dut (
        .CLK             (CLK),
        .RESET_N         (RESET_N),
        .PIX_VALID       (PIX_VALID),
        .PIX_DATA        (PIX_DATA),
        .PIX_READY       (PIX_READY),
        .CLEAR           (CLEAR),
        .integral_buffer (ib),
        .START           (START),
        .is_face         (is_face),
        .FACE_OUT        (FACE_OUT),
        .FACE_VALID      (FACE_VALID)
`ifdef SQ_INTEGRAL_EN
        ,
        .sq_integral_buffer (sqb)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int idx;
        int val;
        int sq;
    } exp_t;

    exp_t sb[$];
    int   img      [WIN_SIZE];
    int   prev_exp [WIN_SIZE];
    int   n_vec   = 0;
    int   n_err   = 0;
    int   acc_cnt = 0;
    int   st_cnt  = 0;

    // Sampled mid-cycle so combinational handshake outputs are settled.
    always @(negedge CLK) begin
        if (PIX_VALID && PIX_READY && !CLEAR) acc_cnt++;
        if (START) st_cnt++;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int rect(input int x, input int y, input bit sq);
        int s = 0;
        for (int j = 0; j <= y; j++)
            for (int i = 0; i <= x; i++)
                s += sq ? img[j*20+i] * img[j*20+i] : img[j*20+i];
        return s;
    endfunction

    task automatic feed(input int k, input int p);
        exp_t e;
        img[k] = p;
        if (k inside {0, 19, 20, 21, 210, 399}) begin
            e.idx = k;
            e.val = rect(k % 20, k / 20, 1'b0);
            e.sq  = rect(k % 20, k / 20, 1'b1);
            sb.push_back(e);
        end
        PIX_VALID = 1'b1;
        PIX_DATA  = PW'(p);
        for (int t = 0; t < 16 && !PIX_READY; t++) tick();
        if (!PIX_READY) chk("ready_timeout", PIX_READY, 1);
        tick();
    endtask

    // Called at N+1, i.e. straight after the last pixel of a window was accepted.
    task automatic finish_window(input bit exp_face);
        exp_t e;
        chk("start_n1", START, 1);
        chk("ready_n1", PIX_READY, 0);
        chk("fvalid_n1", FACE_VALID, 0);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk($sformatf("ib[%0d]", e.idx), ib[e.idx], e.val);
`ifdef SQ_INTEGRAL_EN
            chk($sformatf("sq[%0d]", e.idx), sqb[e.idx], e.sq);
`endif
        end
        for (int k = 0; k < 400; k++) prev_exp[k] = rect(k % 20, k / 20, 1'b0);
        tick();
        chk("start_n2", START, 0);
        chk("fvalid_n2", FACE_VALID, 1);
        chk("face_out_n2", FACE_OUT, exp_face);
        chk("ready_n2", PIX_READY, 1);
    endtask

    initial begin
        RESET_N   = 1'b1;
        PIX_VALID = 1'b0;
        PIX_DATA  = '0;
        CLEAR     = 1'b0;
        is_face   = 1'b0;
        #3 RESET_N = 1'b0;
        #10;
        chk("rst_start", START, 0);
        chk("rst_fvalid", FACE_VALID, 0);
        chk("rst_face", FACE_OUT, 0);
        chk("rst_ib0", ib[0], 0);
        chk("rst_ib399", ib[399], 0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        chk("rst_ready", PIX_READY, 1);
        tick();

        // Window of 1s, back-to-back; valid stays high into COMPARE.
        for (int k = 0; k < 400; k++) feed(k, 1);
        PIX_DATA = 8'd255;
        finish_window(1'b0);

        // Window of 255s, first pixel accepted at N+2 as (0,0).
        is_face = 1'b1;
        for (int k = 0; k < 400; k++) feed(k, 255);
        PIX_VALID = 1'b0;
        finish_window(1'b1);

        // Ramp p=x with a stall cycle between pixels; stalled entries keep old values.
        is_face = 1'b0;
        for (int k = 0; k < 400; k++) begin
            feed(k, k % 20);
            if (k == 5) begin
                chk("face_hold", FACE_OUT, 1);
                chk("fvalid_pulse", FACE_VALID, 0);
            end
            if (k < 399) begin
                PIX_VALID = 1'b0;
                tick();
                chk($sformatf("stall_ib[%0d]", k + 1), ib[k+1], prev_exp[k+1]);
            end
        end
        PIX_VALID = 1'b0;
        finish_window(1'b0);

        // CLEAR after 150 pixels, with a pixel offered in the same cycle.
        is_face = 1'b1;
        for (int k = 0; k < 150; k++) feed(k, 7);
        PIX_VALID = 1'b1;
        PIX_DATA  = 8'd2;
        CLEAR     = 1'b1;
        acc_cnt   = 0;
        st_cnt    = 0;
        tick();
        CLEAR     = 1'b0;
        PIX_VALID = 1'b0;
        sb.delete();
        chk("clr_ready", PIX_READY, 1);
        chk("clr_start", START, 0);
        for (int k = 0; k < 400; k++) feed(k, 2);
        PIX_VALID = 1'b0;
        finish_window(1'b1);
        chk("clr_accepted", acc_cnt, 400);
        chk("clr_starts", st_cnt, 1);

        // Asynchronous reset part-way through a window.
        is_face = 1'b0;
        for (int k = 0; k < 250; k++) feed(k, 3);
        PIX_VALID = 1'b0;
        #2 RESET_N = 1'b0;
        #1;
        chk("arst_start", START, 0);
        chk("arst_fvalid", FACE_VALID, 0);
        chk("arst_face", FACE_OUT, 0);
        chk("arst_ib0", ib[0], 0);
        chk("arst_ib249", ib[249], 0);
        @(posedge CLK);
        #1 RESET_N = 1'b1;
        sb.delete();
        chk("arst_ready", PIX_READY, 1);
        for (int k = 0; k < 400; k++) feed(k, 1);
        PIX_VALID = 1'b0;
        finish_window(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
